// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: locks to a camera frame, packs byte pairs into RGB565 pixels and writes a window to scratchpad
module cam_capture_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DIM_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DIM_WIDTH-1:0]  col_start,
  input  logic [DIM_WIDTH-1:0]  col_count,
  input  logic [DIM_WIDTH-1:0]  row_start,
  input  logic [DIM_WIDTH-1:0]  row_count,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic                  cam_byte_en,
  input  logic [7:0]            cam_dat,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_err,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]           wr_data,
  output logic [ADDR_WIDTH:0]   pix_count
);
  typedef enum logic [2:0] {IDLE, SYNC, ARM, ACTIVE, DONE} state_t;
  state_t               state;
  logic [DIM_WIDTH-1:0] cs, cc, rs, rc;
  logic [DIM_WIDTH:0]   row_idx;
  logic [DIM_WIDTH+1:0] col_byte;
  logic                 href_q;
  logic [7:0]           hi;
  logic                 rise, fall, strobe, in_win, last_row;
  logic [DIM_WIDTH+1:0] cb;
  logic [DIM_WIDTH:0]   col, col_end, row_end, row_nxt;
  // Line edge detection and window membership of the byte being sampled this cycle
  always_comb begin
    rise     = cam_href & ~href_q;
    fall     = href_q & ~cam_href;
    strobe   = cam_byte_en & cam_href;
    cb       = rise ? '0 : col_byte;
    col      = cb[DIM_WIDTH+1:1];
    col_end  = {1'b0, cs} + {1'b0, cc};
    row_end  = {1'b0, rs} + {1'b0, rc};
    row_nxt  = row_idx + 1'b1;
    in_win   = (col >= {1'b0, cs}) && (col < col_end) && (row_idx >= {1'b0, rs}) && (row_idx < row_end);
    last_row = fall && (row_nxt == row_end);
  end
  // Capture sequencer with registered outputs; abort overrides every state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      pix_count <= '0;
      cs        <= '0;
      cc        <= '0;
      rs        <= '0;
      rc        <= '0;
      row_idx   <= '0;
      col_byte  <= '0;
      href_q    <= 1'b0;
      hi        <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (wr_en) wr_addr <= wr_addr + 1'b1;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            cs        <= col_start;
            cc        <= col_count;
            rs        <= row_start;
            rc        <= row_count;
            frame_err <= 1'b0;
            pix_count <= '0;
            wr_addr   <= '0;
            if (col_count == '0 || row_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SYNC;
              busy  <= 1'b1;
            end
          end
          SYNC: if (cam_vsync) state <= ARM;
          ARM: if (!cam_vsync) begin
            state    <= ACTIVE;
            row_idx  <= '0;
            col_byte <= '0;
            href_q   <= 1'b0;
          end
          ACTIVE: begin
            href_q <= cam_href;
            if (strobe) begin
              col_byte <= cb + 1'b1;
              if (!cb[0]) hi <= cam_dat;
              else if (in_win) begin
                wr_en     <= 1'b1;
                wr_data   <= {hi, cam_dat};
                pix_count <= (pix_count != '1) ? pix_count + 1'b1 : pix_count;
              end
            end else if (rise) col_byte <= '0;
            if (fall) row_idx <= row_nxt;
            if (last_row || cam_vsync) begin
              state     <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              frame_err <= frame_err | ~last_row;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb_cam_capture_ctrl: directed checks of window capture, frame error, abort, address wrap and reset
module tb_cam_capture_ctrl;
  logic        clk = 0, resetn = 0, start = 0, abort = 0;
  logic [9:0]  col_start = 0, col_count = 0, row_start = 0, row_count = 0;
  logic        cam_vsync = 0, cam_href = 0, cam_byte_en = 0;
  logic [7:0]  cam_dat = 0;
  logic        busy, done, frame_err, wr_en;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic [12:0] pix_count;
  logic        busy2, done2, frame_err2, wr_en2;
  logic [2:0]  wr_addr2;
  logic [15:0] wr_data2;
  logic [3:0]  pix_count2;
  int          n_assert = 0, n_fail = 0, done_cnt = 0, b, d;
  logic [11:0] wa[$];
  logic [15:0] wd[$];
  logic [2:0]  wa2[$];

  cam_capture_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .col_start(col_start), .col_count(col_count), .row_start(row_start), .row_count(row_count),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_byte_en(cam_byte_en), .cam_dat(cam_dat),
    .busy(busy), .done(done), .frame_err(frame_err), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .pix_count(pix_count)
  );

  cam_capture_ctrl #(.ADDR_WIDTH(3)) dut2 (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .col_start(col_start), .col_count(col_count), .row_start(row_start), .row_count(row_count),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_byte_en(cam_byte_en), .cam_dat(cam_dat),
    .busy(busy2), .done(done2), .frame_err(frame_err2), .wr_en(wr_en2),
    .wr_addr(wr_addr2), .wr_data(wr_data2), .pix_count(pix_count2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
    if (wr_en2) wa2.push_back(wr_addr2);
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic h, input logic e, input logic [7:0] dat);
    @(negedge clk);
    cam_vsync = v; cam_href = h; cam_byte_en = e; cam_dat = dat;
  endtask

  task automatic line(input int r);
    for (int i = 0; i < 16; i++) cyc(0, 1, 1, 8'(r * 16 + i));
    repeat (3) cyc(0, 0, 0, 0);
  endtask

  task automatic frame(input int n);
    repeat (3) cyc(1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    for (int r = 0; r < n; r++) line(r);
    repeat (2) cyc(0, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
  endtask

  task automatic go(input int cs, input int cc, input int rs, input int rc);
    col_start = 10'(cs); col_count = 10'(cc); row_start = 10'(rs); row_count = 10'(rc);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic check_win(input string tag, input int base);
    chk({tag, "_nwr"}, wa.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      int r, c;
      r = 1 + i / 4;
      c = 2 + i % 4;
      chk($sformatf("%s_addr%0d", tag, i), wa[base + i], i);
      chk($sformatf("%s_data%0d", tag, i), wd[base + i], {8'(r * 16 + 2 * c), 8'(r * 16 + 2 * c + 1)});
    end
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_pix", pix_count, 0);
    repeat (2) @(negedge clk);
    resetn = 1;
    // basic window capture
    b = wa.size(); d = done_cnt;
    go(2, 4, 1, 2);
    chk("t1_busy_rise", busy, 1);
    frame(4);
    check_win("t1", b);
    chk("t1_done", done_cnt - d, 1);
    chk("t1_err", frame_err, 0);
    chk("t1_pix", pix_count, 8);
    chk("t1_busy_end", busy, 0);
    // start in the middle of a frame
    b = wa.size(); d = done_cnt;
    line(0);
    go(2, 4, 1, 2);
    line(1);
    line(2);
    chk("t2_nowr_early", wa.size() - b, 0);
    frame(4);
    check_win("t2", b);
    chk("t2_done", done_cnt - d, 1);
    chk("t2_pix", pix_count, 8);
    // window taller than the frame
    b = wa.size(); d = done_cnt;
    go(0, 4, 0, 6);
    frame(4);
    chk("t3_nwr", wa.size() - b, 16);
    chk("t3_err", frame_err, 1);
    chk("t3_done", done_cnt - d, 1);
    chk("t3_pix", pix_count, 16);
    chk("t3_pix_sat", pix_count2, 15);
    chk("t3_busy", busy, 0);
    // abort after three writes, then a clean capture
    b = wa.size(); d = done_cnt;
    go(0, 8, 0, 1);
    chk("t4_err_clr", frame_err, 0);
    repeat (2) cyc(1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 1, 8'(i));
    abort = 1;
    cyc(0, 1, 1, 8'd7);
    abort = 0;
    repeat (3) cyc(0, 0, 0, 0);
    chk("t4_nwr", wa.size() - b, 3);
    chk("t4_nodone", done_cnt - d, 0);
    chk("t4_busy", busy, 0);
    chk("t4_pix", pix_count, 3);
    b = wa.size(); d = done_cnt;
    go(2, 4, 1, 2);
    frame(4);
    check_win("t4b", b);
    chk("t4b_done", done_cnt - d, 1);
    chk("t4b_pix", pix_count, 8);
    // narrow address wraps
    b = wa.size(); d = wa2.size();
    go(0, 5, 0, 2);
    frame(4);
    chk("t5_nwr2", wa2.size() - d, 10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t5_addr2_%0d", i), wa2[d + i], i % 8);
      chk($sformatf("t5_addr_%0d", i), wa[b + i], i);
    end
    chk("t5_pix2", pix_count2, 10);
    chk("t5_pix", pix_count, 10);
    // empty window completes without capturing
    b = wa.size();
    go(5, 0, 0, 2);
    chk("t6_done", done, 1);
    chk("t6_busy", busy, 0);
    @(negedge clk);
    chk("t6_done_pulse", done, 0);
    repeat (3) @(negedge clk);
    chk("t6_nwr", wa.size() - b, 0);
    // asynchronous reset mid-capture
    go(0, 8, 0, 4);
    repeat (2) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 8'(i));
    @(posedge clk);
    #1;
    chk("t7_pre_wr", wr_en, 1);
    chk("t7_pre_data", wr_data, 16'h0203);
    chk("t7_pre_busy", busy, 1);
    resetn = 0;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    chk("t7_err", frame_err, 0);
    chk("t7_wr_en", wr_en, 0);
    chk("t7_addr", wr_addr, 0);
    chk("t7_data", wr_data, 0);
    chk("t7_pix", pix_count, 0);
    @(negedge clk);
    cam_href = 0; cam_byte_en = 0; resetn = 1;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
